// File: rtl/axis_fifo_wr_if.sv
// axis_fifo_wr_if: write-side bundle of the async AXI-Stream FIFO
//   slave modport  : controller view (AXIS beat in, RAM write port and flags out)
//   master modport : upstream/environment view
//   s_axis_tvalid/tdata/tready : AXI-Stream beat handshake
//   rq2_rptr_gray              : read pointer synchronized into this clock, Gray
//   wptr_gray                  : write pointer to the read-domain synchronizer, Gray
//   mem_we/mem_waddr/mem_wdata : dual-port RAM write port
//   full/almost_full/wr_level  : write-side fill status
interface axis_fifo_wr_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  s_axis_tvalid;
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tready;
  logic [ADDR_WIDTH:0]   rq2_rptr_gray;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, rq2_rptr_gray,
    output s_axis_tready, wptr_gray, mem_we, mem_waddr, mem_wdata, full, almost_full, wr_level
  );
  modport master (
    output s_axis_tvalid, s_axis_tdata, rq2_rptr_gray,
    input  s_axis_tready, wptr_gray, mem_we, mem_waddr, mem_wdata, full, almost_full, wr_level
  );
endinterface

// File: rtl/axis_fifo_wr_ctrl.sv
// axis_fifo_wr_ctrl: write-domain controller of the async AXI-Stream FIFO
//   clk : write-domain clock
//   rst : asynchronous reset, active-high
//   bus : axis_fifo_wr_if.slave (AXIS slave, RAM write port, Gray pointers, flags)
module axis_fifo_wr_ctrl #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_FULL_THRESH = (1 << ADDR_WIDTH) - 2
) (
  input logic           clk,
  input logic           rst,
  axis_fifo_wr_if.slave bus
);
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] AF_THRESH = ALMOST_FULL_THRESH[AW:0];
  logic [AW:0] r_wbin, r_wptr_gray, r_wr_level;
  logic        r_full, r_almost_full, r_tready;
  logic        w_accept, w_full_next;
  logic [AW:0] w_wbin_next, w_wgray_next, w_rbin, w_level_next, w_full_ptr;
  assign w_accept     = bus.s_axis_tvalid & r_tready;
  assign w_wbin_next  = r_wbin + {{AW{1'b0}}, w_accept};
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal
  assign w_full_ptr   = {~bus.rq2_rptr_gray[AW:AW-1], bus.rq2_rptr_gray[AW-2:0]};
  assign w_full_next  = w_wgray_next == w_full_ptr;
  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  genvar i;
  generate
    for (i = 0; i <= AW; i++) begin : g_g2b
      assign w_rbin[i] = ^(bus.rq2_rptr_gray >> i);
    end
  endgenerate
  assign w_level_next = w_wbin_next - w_rbin;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wbin        <= '0;
      r_wptr_gray   <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_wr_level    <= '0;
      r_tready      <= 1'b0;
    end else begin
      r_wbin        <= w_wbin_next;
      r_wptr_gray   <= w_wgray_next;
      r_full        <= w_full_next;
      r_almost_full <= w_level_next >= AF_THRESH;
      r_wr_level    <= w_level_next;
      r_tready      <= ~w_full_next;
    end
  end
  assign bus.s_axis_tready = r_tready;
  assign bus.wptr_gray     = r_wptr_gray;
  assign bus.full          = r_full;
  assign bus.almost_full   = r_almost_full;
  assign bus.wr_level      = r_wr_level;
  assign bus.mem_we        = w_accept;
  assign bus.mem_waddr     = r_wbin[AW-1:0];
  assign bus.mem_wdata     = bus.s_axis_tdata;
endmodule
